writeback_stage: RTL and testbench

- Consumer end of the MEMEX->WB pipeline register in the RV32E core.
- Selects the destination data from ALU result, load data, pc+4 or immediate.
- Aligns and extends load data, and waits for the data-memory read response, stalling upstream until it arrives.
- Drives the register-file write port, a one-entry bypass register and the 64-bit retired-instruction counter.

---
 rtl/writeback_stage.sv | 124 ++++++++++++
 tb/tb_writeback_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage of the RV32E pipeline. It selects the destination data, aligns loads,
// waits for the data-memory response, and maintains the bypass register and instret.
//
// state     | meaning
// IDLE      | slot completes this cycle (or is a misaligned load, or a fresh load awaiting data)
// WAIT_LOAD | aligned load held in WB, upstream stalled until dmem_rvalid
module writeback_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 invalid_WB,
  input  logic                 stalled_WB,
  input  logic [XLEN-1:0]      pc4_WB,
  input  logic [3:0]           rd_WB,
  input  logic [XLEN-1:0]      alu_result_WB,
  input  logic                 regfile_we_WB,
  input  logic [1:0]           rd_data_sel_WB,
  input  logic                 lsu_sign_extend_WB,
  input  logic [1:0]           data_width_WB,
  input  logic [XLEN-1:0]      immediate_WB,
  input  logic [XLEN-1:0]      dmem_rdata,
  input  logic                 dmem_rvalid,
  output logic                 regfile_we,
  output logic [3:0]           regfile_waddr,
  output logic [XLEN-1:0]      regfile_wdata,
  output logic                 stall_WB,
  output logic                 load_misaligned,
  output logic                 fwd_valid,
  output logic [3:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t          state, state_nxt;
  logic            live, load_slot, misaligned, load_ok, complete;
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  assign live      = !invalid_WB && !stalled_WB;
  assign load_slot = live && (rd_data_sel_WB == 2'b01);
  assign off       = alu_result_WB[1:0];

  assign misaligned = load_slot &&
                      (((data_width_WB == 2'b01) && off[0]) ||
                       ((data_width_WB == 2'b10) && (off != 2'b00)) ||
                       (data_width_WB == 2'b11));

  // Aligned load whose data is on the bus this cycle; valid from either state.
  assign load_ok  = load_slot && !misaligned && dmem_rvalid;
  assign complete = ((state == IDLE) && live && !load_slot) || load_ok;

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (off)
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
  end

  assign half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_data = dmem_rdata;
    case (data_width_WB)
      2'b00:   load_data = {{(XLEN-8){lsu_sign_extend_WB && byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{(XLEN-16){lsu_sign_extend_WB && half_sel[15]}}, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (load_slot && !misaligned && !dmem_rvalid) state_nxt = WAIT_LOAD;
      WAIT_LOAD: if (dmem_rvalid) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    regfile_we    = !rst && complete && regfile_we_WB && (rd_WB != 4'd0);
    regfile_waddr = rd_WB;
    stall_WB      = !rst && load_slot && !misaligned && !dmem_rvalid;
    regfile_wdata = alu_result_WB;
    case (rd_data_sel_WB)
      2'b01:   regfile_wdata = load_data;
      2'b10:   regfile_wdata = pc4_WB;
      2'b11:   regfile_wdata = immediate_WB;
      default: regfile_wdata = alu_result_WB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret         <= '0;
      fwd_valid       <= 1'b0;
      fwd_rd          <= 4'd0;
      fwd_data        <= '0;
      load_misaligned <= 1'b0;
    end else begin
      load_misaligned <= misaligned && (state == IDLE);
      if (complete) instret <= instret + INSTRET_W'(1);
      if (regfile_we) begin
        fwd_valid <= 1'b1;
        fwd_rd    <= regfile_waddr;
        fwd_data  <= regfile_wdata;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: hand-computed vectors checked with immediate assertions.
module tb_writeback_stage;
  logic        clk, rst;
  logic        invalid_WB, stalled_WB;
  logic [31:0] pc4_WB, alu_result_WB, immediate_WB, dmem_rdata;
  logic [3:0]  rd_WB;
  logic        regfile_we_WB, lsu_sign_extend_WB, dmem_rvalid;
  logic [1:0]  rd_data_sel_WB, data_width_WB;
  logic        regfile_we, stall_WB, load_misaligned, fwd_valid;
  logic [3:0]  regfile_waddr, fwd_rd;
  logic [31:0] regfile_wdata, fwd_data;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk(clk), .rst(rst),
    .invalid_WB(invalid_WB), .stalled_WB(stalled_WB),
    .pc4_WB(pc4_WB), .rd_WB(rd_WB), .alu_result_WB(alu_result_WB),
    .regfile_we_WB(regfile_we_WB), .rd_data_sel_WB(rd_data_sel_WB),
    .lsu_sign_extend_WB(lsu_sign_extend_WB), .data_width_WB(data_width_WB),
    .immediate_WB(immediate_WB), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .regfile_we(regfile_we), .regfile_waddr(regfile_waddr), .regfile_wdata(regfile_wdata),
    .stall_WB(stall_WB), .load_misaligned(load_misaligned),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic inv, input logic stl, input logic [3:0] rd,
                      input logic we, input logic [1:0] sel, input logic [31:0] alu,
                      input logic sx, input logic [1:0] dw);
    invalid_WB         = inv;
    stalled_WB         = stl;
    rd_WB              = rd;
    regfile_we_WB      = we;
    rd_data_sel_WB     = sel;
    alu_result_WB      = alu;
    lsu_sign_extend_WB = sx;
    data_width_WB      = dw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc4_WB = 32'h0000_0208;
    immediate_WB = 32'hDEAD_0000;
    dmem_rdata = 32'h0;
    dmem_rvalid = 1'b0;
    slot(1'b0, 1'b0, 4'd5, 1'b1, 2'b00, 32'h1234, 1'b0, 2'b10);
    #2;
    check("rst_we", regfile_we, 0);
    check("rst_stall", stall_WB, 0);
    check("rst_instret", instret, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_fwd_rd", fwd_rd, 0);
    check("rst_fwd_data", fwd_data, 0);
    check("rst_misaligned", load_misaligned, 0);
    tick();
    tick();
    rst = 1'b0;

    // ALU write to x5
    #1;
    check("alu_we", regfile_we, 1);
    check("alu_waddr", regfile_waddr, 5);
    check("alu_wdata", regfile_wdata, 32'h1234);
    check("alu_stall", stall_WB, 0);
    tick();
    check("alu_fwd_valid", fwd_valid, 1);
    check("alu_fwd_rd", fwd_rd, 5);
    check("alu_fwd_data", fwd_data, 32'h1234);
    check("alu_instret", instret, 1);

    slot(1'b0, 1'b0, 4'd7, 1'b1, 2'b10, 32'h0, 1'b0, 2'b10);
    #1;
    check("pc4_wdata", regfile_wdata, 32'h208);
    check("pc4_waddr", regfile_waddr, 7);
    tick();
    slot(1'b0, 1'b0, 4'd3, 1'b1, 2'b11, 32'h0, 1'b0, 2'b10);
    #1;
    check("imm_wdata", regfile_wdata, 32'hDEAD_0000);
    tick();
    check("imm_fwd_rd", fwd_rd, 3);
    check("imm_fwd_data", fwd_data, 32'hDEAD_0000);
    check("imm_instret", instret, 3);

    // Loads with data already valid
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_0000;
    slot(1'b0, 1'b0, 4'd9, 1'b1, 2'b01, 32'h103, 1'b1, 2'b00);
    #1;
    check("lb_wdata", regfile_wdata, 32'hFFFF_FF80);
    check("lb_we", regfile_we, 1);
    check("lb_stall", stall_WB, 0);
    tick();
    dmem_rdata = 32'h1234_5678;
    slot(1'b0, 1'b0, 4'd9, 1'b1, 2'b01, 32'h101, 1'b0, 2'b00);
    #1;
    check("lbu_wdata", regfile_wdata, 32'h0000_0056);
    tick();
    dmem_rdata = 32'h1234_8001;
    slot(1'b0, 1'b0, 4'd9, 1'b1, 2'b01, 32'h100, 1'b1, 2'b01);
    #1;
    check("lh_wdata", regfile_wdata, 32'hFFFF_8001);
    tick();
    dmem_rdata = 32'hCAFE_F00D;
    slot(1'b0, 1'b0, 4'd9, 1'b1, 2'b01, 32'h104, 1'b1, 2'b10);
    #1;
    check("lw_wdata", regfile_wdata, 32'hCAFE_F00D);
    tick();
    check("loads_instret", instret, 7);
    check("lw_fwd_data", fwd_data, 32'hCAFE_F00D);

    // Half unsigned load with 3 cycles of wait
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    slot(1'b0, 1'b0, 4'd10, 1'b1, 2'b01, 32'h102, 1'b0, 2'b01);
    #1;
    check("wait1_stall", stall_WB, 1);
    check("wait1_we", regfile_we, 0);
    tick();
    check("wait2_stall", stall_WB, 1);
    check("wait2_instret", instret, 7);
    tick();
    check("wait3_stall", stall_WB, 1);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_0000;
    #1;
    check("lhu_stall", stall_WB, 0);
    check("lhu_we", regfile_we, 1);
    check("lhu_wdata", regfile_wdata, 32'h0000_BEEF);
    tick();
    check("lhu_instret", instret, 8);
    check("lhu_fwd_rd", fwd_rd, 10);
    check("lhu_fwd_data", fwd_data, 32'h0000_BEEF);

    // Misaligned word load
    slot(1'b0, 1'b0, 4'd12, 1'b1, 2'b01, 32'h101, 1'b0, 2'b10);
    #1;
    check("mis_we", regfile_we, 0);
    check("mis_stall", stall_WB, 0);
    check("mis_pulse_pre", load_misaligned, 0);
    tick();
    check("mis_pulse", load_misaligned, 1);
    check("mis_instret", instret, 8);
    slot(1'b1, 1'b0, 4'd12, 1'b1, 2'b01, 32'h101, 1'b0, 2'b10);
    tick();
    check("mis_pulse_end", load_misaligned, 0);

    // Squashed, bubble and JAL to x0
    dmem_rvalid = 1'b0;
    slot(1'b1, 1'b0, 4'd4, 1'b1, 2'b00, 32'h55, 1'b0, 2'b10);
    #1;
    check("inv_we", regfile_we, 0);
    tick();
    slot(1'b0, 1'b1, 4'd4, 1'b1, 2'b00, 32'h55, 1'b0, 2'b10);
    #1;
    check("bubble_we", regfile_we, 0);
    tick();
    check("bubble_instret", instret, 8);
    slot(1'b0, 1'b0, 4'd0, 1'b1, 2'b10, 32'h0, 1'b0, 2'b10);
    #1;
    check("jal_x0_we", regfile_we, 0);
    tick();
    check("jal_x0_instret", instret, 9);
    check("jal_x0_fwd_rd", fwd_rd, 10);
    check("jal_x0_fwd_data", fwd_data, 32'h0000_BEEF);

    // Reset while waiting for a load
    slot(1'b0, 1'b0, 4'd11, 1'b1, 2'b01, 32'h200, 1'b0, 2'b10);
    tick();
    check("rstw_stall", stall_WB, 1);
    rst = 1'b1;
    #1;
    check("rstw_instret", instret, 0);
    check("rstw_fwd_valid", fwd_valid, 0);
    check("rstw_stall_low", stall_WB, 0);
    tick();
    rst = 1'b0;
    slot(1'b1, 1'b0, 4'd11, 1'b1, 2'b01, 32'h200, 1'b0, 2'b10);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    #1;
    check("post_rst_we", regfile_we, 0);
    tick();
    check("post_rst_instret", instret, 0);
    check("post_rst_fwd_valid", fwd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
